// File: rtl/vending_return_controller.sv
// vending_return_controller: inactivity timer and largest-first coin return sequencer.
module vending_return_controller #(
  parameter int WAIT_CYCLES = 10,
  parameter int kTotalBits  = 31,
  parameter int COIN_VAL0   = 100,
  parameter int COIN_VAL1   = 500,
  parameter int COIN_VAL2   = 1000,
  parameter int kNumItems   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            i_input_coin,
  input  logic [kNumItems-1:0]  i_output_item,
  input  logic                  i_trigger_return,
  input  logic [kTotalBits-1:0] current_total,
  output logic [31:0]           wait_time,
  output logic [2:0]            o_return_coin,
  output logic                  o_busy,
  output logic                  o_return_done
);
  localparam logic [31:0] WAIT = 32'(WAIT_CYCLES);
  localparam logic [kTotalBits-1:0] V0 = kTotalBits'(COIN_VAL0);
  localparam logic [kTotalBits-1:0] V1 = kTotalBits'(COIN_VAL1);
  localparam logic [kTotalBits-1:0] V2 = kTotalBits'(COIN_VAL2);
  typedef enum logic [1:0] {S_ACTIVE, S_SETTLE, S_RETURN} state_t;
  state_t state_q, state_d;
  logic [31:0] wait_q, wait_d;
  logic [kTotalBits-1:0] rem_q, rem_d, coin_val;
  logic done_q, done_d, activity, rem_low;
  assign activity = |i_input_coin || |i_output_item;
  assign rem_low = rem_q < V0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_ACTIVE;
      wait_q  <= WAIT;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_ACTIVE: state_d = (i_trigger_return || (wait_q == '0 && current_total != '0)) ? S_SETTLE : S_ACTIVE;
      S_SETTLE: state_d = S_RETURN;
      S_RETURN: state_d = rem_low ? S_ACTIVE : S_RETURN;
      default:  state_d = S_ACTIVE;
    endcase
  end
  // A zero timer always reloads: either we leave for SETTLE or the machine is empty.
  always_comb begin
    wait_d = wait_q;
    rem_d  = rem_q;
    done_d = 1'b0;
    if (state_q == S_ACTIVE)
      wait_d = (activity || wait_q == '0) ? WAIT : (current_total == '0) ? wait_q : wait_q - 32'd1;
    if (state_q == S_SETTLE)
      rem_d = current_total;
    if (state_q == S_RETURN) begin
      rem_d  = rem_q - coin_val;
      wait_d = rem_low ? WAIT : wait_q;
      done_d = rem_low;
    end
  end
  always_comb begin
    o_return_coin = (state_q != S_RETURN) ? 3'b000 :
                    (rem_q >= V2) ? 3'b100 : (rem_q >= V1) ? 3'b010 : (rem_q >= V0) ? 3'b001 : 3'b000;
    coin_val      = o_return_coin[2] ? V2 : o_return_coin[1] ? V1 : o_return_coin[0] ? V0 : '0;
    wait_time     = (state_q == S_ACTIVE) ? wait_q : 32'd0;
    o_busy        = state_q != S_ACTIVE;
    o_return_done = done_q;
  end
endmodule
